dft_sample_scheduler: RTL and testbench
=======================================

// Module: dft_sample_scheduler
// PURPOSE
// - Sits between the audio sample source and the DFT block. Feeds samples to the DFT as inputSample/sampleReady.
// - Buffers incoming samples in a small FIFO and enforces a minimum spacing between sampleReady pulses so the
//   DFT finishes each bin-update sweep before the next sample arrives.
// - Counts issued samples and flags frame completion so downstream logic knows when outBins is fresh.
// PARAMETERS
// - SW       16    sample width, two's complement
// - DEPTH    16    FIFO depth in entries, power of 2, >=2
// - SPACING  251   exact cycle distance between consecutive sampleReady pulses, >=4
// - FRAME    1080  issued samples per frame; frameDone fires once per FRAME samples
// PORTS
// - clk         in   1        clock, all logic on posedge
// - rst         in   1        asynchronous, active-low reset
// - enable      in   1        1 = issue samples to DFT; 0 = hold (FIFO still fills)
// - clear       in   1        sync flush: empty FIFO, zero frame count, abort WAIT, go to IDLE
// - inSample    in   SW       sample from source
// - inValid     in   1        inSample valid this cycle
// - inReady     out  1        FIFO can accept (transfer = inValid & inReady)
// - outSample   out  SW       to DFT inputSample; stable from pulse until next pulse
// - sampleReady out  1        1-cycle pulse to DFT
// - frameDone   out  1        1-cycle pulse, see BEHAVIOUR
// - fifoLevel   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, state IDLE, sampleReady=0, frameDone=0, outSample=0, fifoLevel=0,
//   inReady=1, frame count=0. Reset mid-WAIT discards the wait and all buffered samples.
// - FSM: IDLE -> ISSUE when enable & FIFO non-empty & !clear.
// - ISSUE: sampleReady=1 and outSample=FIFO head, both registered. Pop head. Load wait counter. Go to WAIT.
// - WAIT: counter runs down. On expiry, if enable & non-empty, go straight to ISSUE. Otherwise go to IDLE.
// - Timing: with the FIFO continuously non-empty and enable=1, pulses are exactly SPACING cycles apart.
// - Latency: push into an empty FIFO while IDLE -> sampleReady 2 cycles after the push edge.
// - enable falling during WAIT: the current wait completes and no further issue occurs. sampleReady is never cut short.
// - FIFO push: a push when full is not accepted. inReady = !full and is registered from occupancy.
//   Push+pop in the same cycle when full: the pop succeeds and the push is refused, because inReady was 0.
//   Push+pop in the same cycle when empty: the push lands and nothing is popped.
// - Frame: the count increments on each ISSUE. When the FRAME-th sample's wait expires, frameDone=1 for
//   1 cycle and the count wraps to 0. Aborting via clear or rst suppresses that frameDone.
// - clear has priority over push, pop and issue in the same cycle. sampleReady=0 in the clear cycle.
// - All counters are unsigned and sized with $clog2 of their maximum value. No wrap occurs except the frame count at FRAME.
// CONFIGURATION
// - DFT_SCHED_DROP_EN undefined: backpressure mode as above.
// - DFT_SCHED_DROP_EN defined: inReady is tied to 1. A push when full is silently dropped (FIFO contents unchanged).
//   A 16-bit saturating output port dropCount counts the drops, and clear or rst zeroes it.
//   The dropCount port exists only when the macro is defined.
// STRUCTURE
// - Package dft_sched_pkg: state enum {IDLE, ISSUE, WAIT}; default SW/DEPTH/SPACING/FRAME localparams;
//   width helper constants.
// - Sub-module sample_fifo: synchronous FIFO with push/pop/full/empty/level ports, parameterised by SW and DEPTH.
//   The scheduler instantiates one sample_fifo.
// TESTING
// - Reset, then push 1 sample 0x1234 with enable=1 -> sampleReady 2 cycles later, outSample=0x1234, inReady=1.
// - Burst of 16 pushes at DEPTH=16 -> inReady drops after the 16th push. Pulses are spaced exactly 251 cycles apart,
//   and inReady returns 1 cycle after the first pop.
// - Run FRAME=8 with 8 samples -> frameDone pulses once, 251 cycles after the 8th sampleReady; the count wraps.
//   A 9th sample gives no extra frameDone.
// - Drop enable mid-WAIT with 3 samples queued -> the current wait finishes and no pulse follows.
//   Re-raise enable -> the next pulse comes 2 cycles later.
// - Pulse clear with 5 queued samples mid-WAIT -> fifoLevel=0 next cycle, no sampleReady and no frameDone.
//   A new push issues 2 cycles later.
// - With DFT_SCHED_DROP_EN: push 20 samples into DEPTH=16 with enable=0 -> dropCount=4 and fifoLevel=16.
//   The first 16 values come out in order.

Source files
------------

// File: rtl/dft_sched_pkg.sv
// dft_sched_pkg: shared types and defaults for the DFT sample scheduler.
// Optional feature macro: DFT_SCHED_DROP_EN (drop-on-full mode with drop counter).
package dft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int SW_DEF      = 16;
  localparam int DEPTH_DEF   = 16;
  localparam int SPACING_DEF = 251;
  localparam int FRAME_DEF   = 1080;
  localparam int DROP_W      = 16;

  // Bits needed to hold values 0..max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO, flush has priority over push/pop.
// Full flag is registered from next occupancy so it can serve directly as !ready.
module sample_fifo #(
  parameter int SW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [SW-1:0]            i_din,
  output logic [SW-1:0]            o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          r_full;
  logic          w_push, w_pop;

  assign w_push = i_push & ~r_full & ~i_flush;
  assign w_pop  = i_pop & (r_level != '0) & ~i_flush;

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    w_level_nxt = r_level;
    if (i_flush)              w_level_nxt = '0;
    else if (w_push & ~w_pop) w_level_nxt = r_level + 1'b1;
    else if (w_pop & ~w_push) w_level_nxt = r_level - 1'b1;
  end

  // Pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/dft_sample_scheduler.sv
// dft_sample_scheduler: buffers audio samples and issues them to the DFT with a
// fixed pulse spacing, flagging frame completion.
// Optional feature macro: DFT_SCHED_DROP_EN (inReady tied high, full pushes dropped
// and counted on dropCount).
module dft_sample_scheduler
  import dft_sched_pkg::*;
#(
  parameter int SW      = SW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int SPACING = SPACING_DEF,
  parameter int FRAME   = FRAME_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [SW-1:0]          inSample,
  input  logic                   inValid,
  output logic                   inReady,
  output logic [SW-1:0]          outSample,
  output logic                   sampleReady,
  output logic                   frameDone,
  output logic [$clog2(DEPTH):0] fifoLevel
`ifdef DFT_SCHED_DROP_EN
  ,
  output logic [DROP_W-1:0]      dropCount
`endif
);
  // Wait counter holds SPACING-2 so ISSUE(1) + WAIT(SPACING-1) = SPACING cycles
  localparam int WCW = cnt_w(SPACING - 2);
  localparam int FCW = cnt_w(FRAME);

  sched_state_e   r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [FCW-1:0] r_frame_cnt;
  logic           r_sample_ready, r_fd_arm, r_frame_done;
  logic [SW-1:0]  r_out;
  logic           w_issue, w_wait_done, w_frame_end;
  logic           w_full, w_empty;
  logic [SW-1:0]  w_head;

  sample_fifo #(.SW(SW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (clear),
    .i_push  (inValid),
    .i_pop   (w_issue),
    .i_din   (inSample),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifoLevel)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; clear aborts everything back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (enable && !w_empty) w_state_nxt = ISSUE;
        ISSUE:   w_state_nxt = WAIT;
        WAIT:    if (w_wait_done) w_state_nxt = (enable && !w_empty) ? ISSUE : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State decode: issue strobe (pops FIFO) and wait expiry
  always_comb begin
    w_issue     = 1'b0;
    w_wait_done = 1'b0;
    case (r_state)
      ISSUE:   w_issue     = ~clear;
      WAIT:    w_wait_done = (r_wait_cnt == '0) & ~clear;
      default: ;
    endcase
  end

  assign w_frame_end = w_wait_done & (r_frame_cnt == FCW'(FRAME));

  // Wait counter: loaded on issue, runs down to zero in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_wait_cnt <= '0;
    else if (clear)                               r_wait_cnt <= '0;
    else if (w_issue)                             r_wait_cnt <= WCW'(SPACING - 2);
    else if (r_state == WAIT && r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
  end

  // Registered DFT outputs; outSample holds until the next issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_ready <= 1'b0;
      r_out          <= '0;
    end else begin
      r_sample_ready <= w_issue;
      if (w_issue) r_out <= w_head;
    end
  end

  // Frame count and frameDone; the arm stage lines frameDone up with the
  // slot the next pulse would occupy, and clear kills it at either stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt  <= '0;
      r_fd_arm     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_fd_arm     <= w_frame_end;
      r_frame_done <= r_fd_arm & ~clear;
      if (clear)            r_frame_cnt <= '0;
      else if (w_frame_end) r_frame_cnt <= '0;
      else if (w_issue)     r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign sampleReady = r_sample_ready;
  assign outSample   = r_out;
  assign frameDone   = r_frame_done;

`ifdef DFT_SCHED_DROP_EN
  logic [DROP_W-1:0] r_drop_cnt;

  // Saturating count of pushes lost to a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_drop_cnt <= '0;
    else if (clear)                          r_drop_cnt <= '0;
    else if (inValid & w_full & ~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign dropCount = r_drop_cnt;
  assign inReady   = 1'b1;
`else
  assign inReady   = ~w_full;
`endif

endmodule

// File: tb/tb_dft_sample_scheduler.sv
// tb_dft_sample_scheduler: directed scoreboard bench for dft_sample_scheduler.
// Inputs driven on negedge, outputs sampled 1 time unit after posedge.
module tb_dft_sample_scheduler;
  localparam int SW      = 16;
  localparam int DEPTH   = 16;
  localparam int SPACING = 251;
  localparam int FRAME   = 8;
`ifdef DFT_SCHED_DROP_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, enable, clear, inValid;
  logic [SW-1:0]          inSample;
  logic                   inReady, sampleReady, frameDone;
  logic [SW-1:0]          outSample;
  logic [$clog2(DEPTH):0] fifoLevel;
`ifdef DFT_SCHED_DROP_EN
  logic [15:0]            dropCount;
`endif

  dft_sample_scheduler #(.SW(SW), .DEPTH(DEPTH), .SPACING(SPACING), .FRAME(FRAME)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear       (clear),
    .inSample    (inSample),
    .inValid     (inValid),
    .inReady     (inReady),
    .outSample   (outSample),
    .sampleReady (sampleReady),
    .frameDone   (frameDone),
    .fifoLevel   (fifoLevel)
`ifdef DFT_SCHED_DROP_EN
    ,
    .dropCount   (dropCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [SW-1:0] exp_q[$];
  int pulse_t[$];
  int pulse_cnt = 0, last_pulse = -1, fd_cnt = 0, fd_cyc = -1;
  int n_acc = 0, n_pop = 0, n_flush = 0;
  int f_model = 0, exp_fd = -1, last_push = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [SW-1:0] v);
    int lvl;
    lvl = n_acc - n_pop - n_flush;
    inValid = 1'b1;
    inSample = v;
    check("push_inReady", 32'(inReady), 32'(DROP_MODE ? 1'b1 : (lvl != DEPTH)));
    check("push_fifoLevel", 32'(fifoLevel), 32'(lvl));
    if (lvl < DEPTH) begin
      exp_q.push_back(v);
      n_acc++;
    end
    last_push = cyc + 1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(pulse_cnt), 32'(target));
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int base, t0, p0, f0;

  initial begin
    rst = 1'b0; enable = 1'b0; clear = 1'b0; inValid = 1'b0; inSample = '0;

    fork
      // Monitor / scoreboard
      forever begin
        @(posedge clk); #1;
        if (rst) begin
          if (clear) begin
            n_flush = n_acc - n_pop;
            exp_q.delete();
            f_model = 0;
            exp_fd  = -1;
          end
          if (sampleReady) begin
            pulse_cnt++;
            pulse_t.push_back(cyc);
            last_pulse = cyc;
            n_pop++;
            if (exp_q.size() != 0) check("outSample", 32'(outSample), 32'(exp_q.pop_front()));
            else check("sr_unexpected", 32'(sampleReady), 32'(0));
            f_model++;
            if (f_model == FRAME) begin
              f_model = 0;
              exp_fd  = cyc + SPACING;
            end
          end
          if (frameDone || cyc == exp_fd) begin
            check("frameDone", 32'(frameDone), 32'(cyc == exp_fd));
            if (frameDone) begin
              fd_cnt++;
              fd_cyc = cyc;
            end
          end
        end
      end
      // Watchdog
      begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sampleReady", 32'(sampleReady), 32'(0));
    check("rst_frameDone", 32'(frameDone), 32'(0));
    check("rst_outSample", 32'(outSample), 32'(0));
    check("rst_fifoLevel", 32'(fifoLevel), 32'(0));
    check("rst_inReady", 32'(inReady), 32'(1));
    rst = 1'b1;
    @(negedge clk);

    // Single sample latency
    enable = 1'b1;
    push(16'h1234);
    t0 = last_push;
    wait_pulses(1, 20, "t1_pulse");
    check("t1_latency", 32'(last_pulse), 32'(t0 + 2));
    check("t1_inReady", 32'(inReady), 32'(1));
    idle(SPACING + 10);

    // Burst to full, spacing, inReady recovery
    enable = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < DEPTH; i++) push(16'h2000 + 16'(i));
    check("t2_level_full", 32'(fifoLevel), 32'(DEPTH));
    check("t2_inReady_full", 32'(inReady), 32'(DROP_MODE));
    push(16'h2FFF);
    enable = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("t2_inReady_held", 32'(inReady), 32'(DROP_MODE));
    wait_pulses(base + 1, 5, "t2_first_pulse");
    check("t2_first_latency", 32'(last_pulse), 32'(t0 + 2));
    check("t2_inReady_back", 32'(inReady), 32'(1));
    check("t2_level_after_pop", 32'(fifoLevel), 32'(DEPTH - 1));
    wait_pulses(base + DEPTH, DEPTH * SPACING + 20, "t2_all_pulses");
    for (int i = 1; i < DEPTH; i++)
      check("t2_spacing", 32'(pulse_t[base + i] - pulse_t[base + i - 1]), 32'(SPACING));
    idle(SPACING + 10);

    // Frame completion: 11 samples, exactly one frameDone
    clear_pulse();
    base = pulse_cnt;
    f0 = fd_cnt;
    for (int i = 0; i < 11; i++) push(16'h3000 + 16'(i));
    wait_pulses(base + 11, 11 * SPACING + 40, "t3_pulses");
    idle(SPACING + 10);
    check("t3_fd_count", 32'(fd_cnt - f0), 32'(1));
    check("t3_fd_time", 32'(fd_cyc), 32'(pulse_t[base + FRAME - 1] + SPACING));

    // Enable drop mid-WAIT with 3 queued
    enable = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i));
    enable = 1'b1;
    t0 = cyc;
    wait_pulses(base + 1, 10, "t4_first");
    check("t4_first_latency", 32'(last_pulse), 32'(t0 + 2));
    idle(10);
    enable = 1'b0;
    idle(SPACING + 20);
    check("t4_no_pulse", 32'(pulse_cnt), 32'(base + 1));
    check("t4_level", 32'(fifoLevel), 32'(3));
    enable = 1'b1;
    t0 = cyc;
    wait_pulses(base + 2, 10, "t4_resume");
    check("t4_resume_latency", 32'(last_pulse), 32'(t0 + 2));
    wait_pulses(base + 4, 2 * SPACING + 20, "t4_drain");
    idle(SPACING + 10);

    // Clear mid-WAIT with 5 queued; this pulse completes a frame that clear aborts
    enable = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) push(16'h5000 + 16'(i));
    enable = 1'b1;
    t0 = cyc;
    wait_pulses(base + 1, 10, "t5_first");
    check("t5_first_latency", 32'(last_pulse), 32'(t0 + 2));
    idle(20);
    clear_pulse();
    check("t5_level_cleared", 32'(fifoLevel), 32'(0));
    p0 = pulse_cnt;
    f0 = fd_cnt;
    idle(SPACING + 20);
    check("t5_no_pulse", 32'(pulse_cnt), 32'(p0));
    check("t5_no_frameDone", 32'(fd_cnt), 32'(f0));
    push(16'h5555);
    t0 = last_push;
    wait_pulses(p0 + 1, 10, "t5_new");
    check("t5_new_latency", 32'(last_pulse), 32'(t0 + 2));
    idle(SPACING + 10);

`ifdef DFT_SCHED_DROP_EN
    // Drop mode: 20 pushes into 16 entries
    clear_pulse();
    enable = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 20; i++) push(16'h6000 + 16'(i));
    check("t6_dropCount", 32'(dropCount), 32'(4));
    check("t6_level", 32'(fifoLevel), 32'(DEPTH));
    enable = 1'b1;
    wait_pulses(base + DEPTH, DEPTH * SPACING + 20, "t6_drain");
    idle(5);
    check("t6_level_empty", 32'(fifoLevel), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
